// File: rtl/frame_buffer.sv
// Frame FIFO between the trace frame packer and the serialiser: block-RAM storage,
// a prefetched head-frame register on a ready/next handshake, and drop/receive statistics.
module frame_buffer #(
    parameter int unsigned BUFFLENLOG2 = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [127:0]           FrameIn,
    input  logic                   FrameInValid,
    output logic [127:0]           Frame,
    output logic                   FrameReady,
    input  logic                   FrameNext,
    output logic [BUFFLENLOG2-1:0] FramesCnt,
    output logic [15:0]            LostFrames,
    output logic [31:0]            TotalFrames
);

    localparam int unsigned DEPTH  = 1 << BUFFLENLOG2;
    localparam int unsigned FRAMEW = 128;
    localparam logic [BUFFLENLOG2-1:0] MAXCNT  = '1;
    localparam logic [BUFFLENLOG2-1:0] PTRONE  = BUFFLENLOG2'(1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2
    } bufState_t;

    bufState_t               state;
    logic [FRAMEW-1:0]       mem [DEPTH];
    logic [FRAMEW-1:0]       ramQ;
    logic [BUFFLENLOG2-1:0]  wp;
    logic [BUFFLENLOG2-1:0]  rp;
    logic                    live;

    logic inValid;
    logic nextEff;
    logic accept;
    logic unread;

    // Strobes are masked on the first edge after reset release.
    always_comb begin
        inValid = live & FrameInValid;
        nextEff = live & FrameNext & (state == PRESENT);
        accept  = inValid & ((FramesCnt != MAXCNT) | nextEff);
        unread  = (wp != rp);
    end

    // Frame storage with one registered read port; reads always track rp.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wp] <= FrameIn;
        end
        ramQ <= mem[rp];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            wp          <= '0;
            rp          <= '0;
            live        <= 1'b0;
            Frame       <= '0;
            FrameReady  <= 1'b0;
            FramesCnt   <= '0;
            LostFrames  <= '0;
            TotalFrames <= '0;
        end else begin
            live <= 1'b1;

            if (accept) begin
                wp <= wp + PTRONE;
            end

            if (accept && !nextEff) begin
                FramesCnt <= FramesCnt + PTRONE;
            end else if (!accept && nextEff) begin
                FramesCnt <= FramesCnt - PTRONE;
            end

            if (inValid) begin
                TotalFrames <= TotalFrames + 32'd1;
                if (!accept && (LostFrames != 16'hFFFF)) begin
                    LostFrames <= LostFrames + 16'd1;
                end
            end

            // Prefetch: ramQ already holds mem[rp] when FETCH completes.
            case (state)
                EMPTY: begin
                    if (unread) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    state      <= PRESENT;
                    Frame      <= ramQ;
                    FrameReady <= 1'b1;
                    rp         <= rp + PTRONE;
                end
                PRESENT: begin
                    if (nextEff) begin
                        FrameReady <= 1'b0;
                        state      <= unread ? FETCH : EMPTY;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    FrameReady <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer with a 7-frame buffer: latency, ordering across
// pointer wrap, overflow drop, full-with-consume, statistic saturation/wrap and reset.
module tb_frame_buffer;

    localparam int unsigned BL2 = 3;

    logic           clk;
    logic           rst;
    logic [127:0]   FrameIn;
    logic           FrameInValid;
    logic [127:0]   Frame;
    logic           FrameReady;
    logic           FrameNext;
    logic [BL2-1:0] FramesCnt;
    logic [15:0]    LostFrames;
    logic [31:0]    TotalFrames;

    int nChecked = 0;
    int nFailed  = 0;

    frame_buffer #(.BUFFLENLOG2(BL2)) dut (
        .clk          (clk),
        .rst          (rst),
        .FrameIn      (FrameIn),
        .FrameInValid (FrameInValid),
        .Frame        (Frame),
        .FrameReady   (FrameReady),
        .FrameNext    (FrameNext),
        .FramesCnt    (FramesCnt),
        .LostFrames   (LostFrames),
        .TotalFrames  (TotalFrames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nChecked++;
        if (got !== exp) begin
            nFailed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input int n);
        return {32'hCAFE0000 | 32'(n), ~32'(n), 32'(n) * 32'd3, 32'hF00D0000 + 32'(n)};
    endfunction

    // One clock; outputs are sampled and strobes cleared just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        FrameInValid = 1'b0;
        FrameNext    = 1'b0;
    endtask

    task automatic push(input logic [127:0] d);
        FrameIn      = d;
        FrameInValid = 1'b1;
        cyc();
    endtask

    task automatic waitReady(input string tag);
        int n = 0;
        while (!FrameReady && n < 10) begin
            cyc();
            n++;
        end
        check(tag, 128'(FrameReady), 128'(1));
    endtask

    task automatic pop(input string tag, input logic [127:0] exp);
        waitReady({tag, "_ready"});
        check({tag, "_data"}, Frame, exp);
        FrameNext = 1'b1;
        cyc();
        check({tag, "_drop"}, 128'(FrameReady), 128'(0));
    endtask

    initial begin
        rst          = 1'b0;
        FrameIn      = '0;
        FrameInValid = 1'b0;
        FrameNext    = 1'b0;

        // Reset held with random input activity
        for (int i = 0; i < 5; i++) begin
            FrameIn      = {$urandom(), $urandom(), $urandom(), $urandom()};
            FrameInValid = 1'($urandom());
            FrameNext    = 1'($urandom());
            @(posedge clk);
            #1;
        end
        check("rst_frame", Frame, 128'(0));
        check("rst_ready", 128'(FrameReady), 128'(0));
        check("rst_cnt",   128'(FramesCnt), 128'(0));
        check("rst_lost",  128'(LostFrames), 128'(0));
        check("rst_total", 128'(TotalFrames), 128'(0));
        FrameInValid = 1'b0;
        FrameNext    = 1'b0;
        FrameIn      = '0;
        rst          = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("idle_ready", 128'(FrameReady), 128'(0));
        end

        // Single frame: count after k, presented after k+2
        push(128'h0123456789ABCDEF0123456789ABCDEF);
        check("single_cnt_k",    128'(FramesCnt), 128'(1));
        check("single_ready_k",  128'(FrameReady), 128'(0));
        cyc();
        check("single_ready_k1", 128'(FrameReady), 128'(0));
        cyc();
        check("single_ready_k2", 128'(FrameReady), 128'(1));
        check("single_data",     Frame, 128'h0123456789ABCDEF0123456789ABCDEF);
        FrameNext = 1'b1;
        cyc();
        check("single_next_ready", 128'(FrameReady), 128'(0));
        check("single_next_cnt",   128'(FramesCnt), 128'(0));
        for (int i = 0; i < 3; i++) cyc();
        check("single_stay_ready", 128'(FrameReady), 128'(0));
        check("single_stay_frame", Frame, 128'h0123456789ABCDEF0123456789ABCDEF);
        FrameNext = 1'b1;
        cyc();
        check("next_in_empty_cnt", 128'(FramesCnt), 128'(0));

        // Ordering across pointer wrap
        for (int i = 0; i < 5; i++) push(mk(i));
        check("ord5_cnt", 128'(FramesCnt), 128'(5));
        for (int i = 0; i < 5; i++) begin
            pop("ord5", mk(i));
            check("ord5_cnt_dec", 128'(FramesCnt), 128'(4 - i));
        end
        for (int i = 5; i < 12; i++) push(mk(i));
        check("ord7_cnt", 128'(FramesCnt), 128'(7));
        for (int i = 5; i < 12; i++) pop("ord7", mk(i));
        check("ord_cnt_end", 128'(FramesCnt), 128'(0));
        check("ord_lost",    128'(LostFrames), 128'(0));
        check("ord_total",   128'(TotalFrames), 128'(13));

        // Overflow: 10 writes into 7 slots
        for (int i = 20; i < 30; i++) push(mk(i));
        check("ovf_cnt",   128'(FramesCnt), 128'(7));
        check("ovf_lost",  128'(LostFrames), 128'(3));
        check("ovf_total", 128'(TotalFrames), 128'(23));
        for (int i = 20; i < 27; i++) pop("ovf", mk(i));
        for (int i = 0; i < 4; i++) cyc();
        check("ovf_drained_ready", 128'(FrameReady), 128'(0));
        check("ovf_drained_cnt",   128'(FramesCnt), 128'(0));

        // Full with simultaneous write and consume
        for (int i = 30; i < 37; i++) push(mk(i));
        waitReady("full_ready");
        check("full_head", Frame, mk(30));
        FrameIn      = mk(37);
        FrameInValid = 1'b1;
        FrameNext    = 1'b1;
        cyc();
        check("full_sim_cnt",   128'(FramesCnt), 128'(7));
        check("full_sim_lost",  128'(LostFrames), 128'(3));
        check("full_sim_total", 128'(TotalFrames), 128'(31));
        for (int i = 31; i < 38; i++) pop("full", mk(i));

        // Statistic saturation and wrap on a full buffer
        for (int i = 40; i < 47; i++) push(mk(i));
        check("sat_fill_cnt", 128'(FramesCnt), 128'(7));
        dut.LostFrames  = 16'hFFFE;
        dut.TotalFrames = 32'hFFFFFFFE;
        for (int i = 50; i < 53; i++) push(mk(i));
        check("sat_lost",  128'(LostFrames), 128'(16'hFFFF));
        check("sat_total", 128'(TotalFrames), 128'(1));
        check("sat_cnt",   128'(FramesCnt), 128'(7));
        pop("sat", mk(40));
        pop("sat", mk(41));

        // Reset mid-operation discards stored frames
        rst = 1'b0;
        #1;
        check("midrst_cnt",   128'(FramesCnt), 128'(0));
        check("midrst_ready", 128'(FrameReady), 128'(0));
        cyc();
        FrameIn      = mk(60);
        FrameInValid = 1'b1;
        rst          = 1'b1;
        cyc();
        check("release_ignored_cnt",   128'(FramesCnt), 128'(0));
        check("release_ignored_total", 128'(TotalFrames), 128'(0));
        push(mk(61));
        pop("after_rst", mk(61));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecked, nFailed);
        $finish;
    end

endmodule
